// File: rtl/sfx_mixer_if.sv
// Game-audio bundle between the controller and the sfx_mixer output stage.
// The master drives the BGM, event pulses and volume/mute; the slave returns the buzzer drive and effect state.
interface sfx_mixer_if;
  logic       bgm_beep;
  logic       shot_pulse;
  logic       hit_pulse;
  logic       bomb_pulse;
  logic [2:0] vol;
  logic       mute;
  logic       audio_out;
  logic [1:0] sfx_state;

  modport master (
    output bgm_beep, shot_pulse, hit_pulse, bomb_pulse, vol, mute,
    input  audio_out, sfx_state
  );

  modport slave (
    input  bgm_beep, shot_pulse, hit_pulse, bomb_pulse, vol, mute,
    output audio_out, sfx_state
  );
endinterface

// File: rtl/sfx_mixer.sv
// Buzzer output stage: priority sound effects (shot/hit/bomb) replace the BGM,
// followed by 3-bit PWM volume and mute into a registered buzzer drive.
module sfx_mixer #(
  parameter int unsigned TICK     = 50_000,
  parameter int unsigned SHOT_P0  = 20_000,
  parameter int unsigned SHOT_DP  = 400,
  parameter int unsigned SHOT_LEN = 60,
  parameter int unsigned HIT_P0   = 80_000,
  parameter int unsigned HIT_DP   = 1_000,
  parameter int unsigned HIT_LEN  = 150,
  parameter int unsigned BOMB_NP  = 4_000,
  parameter int unsigned BOMB_LEN = 800
) (
  input  logic        clk,
  input  logic        rst_n,
  sfx_mixer_if.slave  bus
);

  localparam int unsigned PW = 18;
  localparam int unsigned MW = 10;
  localparam int unsigned TW = 16;
  localparam int unsigned LW = 16;
  localparam int unsigned NW = (BOMB_NP > 1) ? $clog2(BOMB_NP) : 1;
  localparam logic [LW-1:0] LFSR_SEED = 16'hACE1;

  // Encoding doubles as priority: a larger value wins.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOT = 2'd1,
    ST_HIT  = 2'd2,
    ST_BOMB = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [MW-1:0]   ms_q, ms_d;
  logic [PW-1:0]   tone_cnt_q, tone_cnt_d;
  logic [PW-1:0]   period_q, period_d;
  logic [NW-1:0]   np_q, np_d;
  logic [LW-1:0]   lfsr_q, lfsr_d;
  logic [2:0]      pwm_q, pwm_d;
  logic            audio_q, audio_d;

  state_t          req;
  state_t          eff_state;
  logic            accept;
  logic            tick_wrap;
  logic            end_now;
  logic [MW-1:0]   len_m1;
  logic            tone;
  logic            src;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      ms_q       <= '0;
      tone_cnt_q <= '0;
      period_q   <= '0;
      np_q       <= '0;
      lfsr_q     <= LFSR_SEED;
      pwm_q      <= '0;
      audio_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      ms_q       <= ms_d;
      tone_cnt_q <= tone_cnt_d;
      period_q   <= period_d;
      np_q       <= np_d;
      lfsr_q     <= lfsr_d;
      pwm_q      <= pwm_d;
      audio_q    <= audio_d;
    end
  end

  // Next-state, effect counters and output mixing
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    ms_d       = ms_q;
    tone_cnt_d = tone_cnt_q;
    period_d   = period_q;
    np_d       = np_q;
    lfsr_d     = lfsr_q;
    pwm_d      = pwm_q + 3'd1;
    len_m1     = '0;
    tone       = 1'b0;

    case (state_q)
      ST_SHOT: len_m1 = MW'(SHOT_LEN - 1);
      ST_HIT:  len_m1 = MW'(HIT_LEN - 1);
      ST_BOMB: len_m1 = MW'(BOMB_LEN - 1);
      default: len_m1 = '0;
    endcase

    tick_wrap = (state_q != ST_IDLE) && (tick_q == TW'(TICK - 1));
    end_now   = tick_wrap && (ms_q == len_m1);

    if (bus.bomb_pulse)      req = ST_BOMB;
    else if (bus.hit_pulse)  req = ST_HIT;
    else if (bus.shot_pulse) req = ST_SHOT;
    else                     req = ST_IDLE;

    // A pulse landing on the final tick competes against IDLE, not the ending effect.
    eff_state = end_now ? ST_IDLE : state_q;
    accept    = (req != ST_IDLE) && (req >= eff_state);

    if (state_q != ST_IDLE) begin
      tick_d     = tick_wrap ? '0 : tick_q + TW'(1);
      tone_cnt_d = (tone_cnt_q >= period_q - PW'(1)) ? '0 : tone_cnt_q + PW'(1);
      if (tick_wrap) begin
        ms_d = ms_q + MW'(1);
        if (state_q == ST_SHOT) period_d = period_q + PW'(SHOT_DP);
        if (state_q == ST_HIT)  period_d = period_q + PW'(HIT_DP);
      end
      if (state_q == ST_BOMB) begin
        if (np_q == NW'(BOMB_NP - 1)) begin
          np_d   = '0;
          lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[LW-1:1]};
        end else begin
          np_d = np_q + NW'(1);
        end
      end
      if (end_now) begin
        state_d    = ST_IDLE;
        tick_d     = '0;
        ms_d       = '0;
        tone_cnt_d = '0;
        period_d   = '0;
        np_d       = '0;
      end
    end

    if (accept) begin
      state_d    = req;
      tick_d     = '0;
      ms_d       = '0;
      tone_cnt_d = '0;
      np_d       = '0;
      case (req)
        ST_SHOT: period_d = PW'(SHOT_P0);
        ST_HIT:  period_d = PW'(HIT_P0);
        default: period_d = '0;
      endcase
    end

    case (state_q)
      ST_SHOT, ST_HIT: tone = (tone_cnt_q >= (period_q >> 1));
      ST_BOMB:         tone = lfsr_q[0];
      default:         tone = 1'b0;
    endcase

    src     = (state_q != ST_IDLE) ? tone : bus.bgm_beep;
    audio_d = !bus.mute && src && (pwm_q < bus.vol);
  end

  assign bus.audio_out = audio_q;
  assign bus.sfx_state = state_q;

endmodule

// File: doc/sfx_mixer.md
# sfx_mixer

Audio output stage that sits directly downstream of the background-music player and feeds the board buzzer pin. It takes the BGM square wave, generates three priority-ranked sound effects (shot, hit, bomb) from one-cycle game-event pulses, and replaces the BGM with the active effect. It also applies 3-bit PWM volume and mute to the result.

## Interface
Parameters:
- TICK, 50_000: cycles per sweep/duration tick (1 ms at 50 MHz).
- SHOT_P0, 20_000: shot initial tone period (cycles).
- SHOT_DP, 400: shot period increment per tick.
- SHOT_LEN, 60: shot duration (ticks).
- HIT_P0, 80_000: hit initial period.
- HIT_DP, 1_000: hit period increment per tick.
- HIT_LEN, 150: hit duration (ticks).
- BOMB_NP, 4_000: bomb noise sample period (cycles per LFSR step).
- BOMB_LEN, 800: bomb duration (ticks).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-low.
- bgm_beep  in  1  BGM square wave from the music player, same clock domain.
- shot_pulse  in  1  one-cycle shot event.
- hit_pulse  in  1  one-cycle player-hit event.
- bomb_pulse  in  1  one-cycle bomb event.
- vol  in  3  volume, 0 silent … 7 loudest.
- mute  in  1  forces audio_out low.
- audio_out  out  1  registered buzzer drive.
- sfx_state  out  2  current FSM state: 0 IDLE, 1 SHOT, 2 HIT, 3 BOMB.

## Operation
- FSM states: IDLE, SHOT, HIT, BOMB. Priority is BOMB > HIT > SHOT.
- Trigger acceptance:
  - A pulse whose priority is ≥ the current state's priority enters or restarts that state.
  - A lower-priority pulse is ignored.
  - From IDLE, any pulse is accepted.
- Simultaneous pulses in one cycle: the highest-priority pulse wins.
- On entry or restart:
  - tick_cnt = 0, ms_cnt = 0, tone_cnt = 0.
  - period is loaded with P0 of that effect.
- tick_cnt counts 0..TICK-1 and wraps. Each wrap is a "tick" and causes:
  - ms_cnt += 1.
  - SHOT/HIT: period += DP.
- End of effect: on the tick where ms_cnt == LEN-1, the FSM returns to IDLE. If a pulse is accepted in that same cycle, the pulse takes precedence and enters its state.
- SHOT/HIT tone generator:
  - tone_cnt increments every cycle and wraps to 0 when tone_cnt ≥ period-1. The ≥ comparison keeps the wrap safe when period changes mid-wave.
  - tone = (tone_cnt ≥ period>>1): first half low, second half high.
- BOMB tone:
  - 16-bit Fibonacci LFSR, taps 16, 14, 13, 11, seeded to 16'hACE1 at reset.
  - Steps once every BOMB_NP cycles, only while in BOMB; it is not reseeded on entry.
  - tone = lfsr[0].
- Width rules:
  - period and tone_cnt are 18 bits unsigned; the maximum period HIT_P0 + HIT_LEN·HIT_DP = 230_000 fits.
  - ms_cnt is 10 bits; tick_cnt is 16 bits.
- Source selection: src = tone when sfx_state ≠ IDLE, else bgm_beep. BGM is fully ducked while an effect plays.
- Volume:
  - pwm_cnt is a free-running 3-bit counter.
  - gated = src & (pwm_cnt < vol), so vol 0 gives a constant 0 and vol 7 gives 7/8 duty.
- Output: audio_out ← mute ? 0 : gated, registered. The FSM and counters keep running while muted.

## Timing
- Reset values: audio_out = 0, sfx_state = 0 (IDLE), all counters 0, period 0, lfsr 16'hACE1.
- Trigger sampled at edge N: sfx_state and counters are updated after edge N. audio_out reflects the effect tone after edge N+1. Latency from pulse to output is 2 cycles.
- bgm_beep to audio_out: 1-cycle latency (a single output register).
- Effect duration is exactly LEN·TICK cycles from the entry edge to the edge at which the FSM enters IDLE.
- Reset asserted mid-effect:
  - All state clears immediately.
  - audio_out goes to 0 asynchronously.
  - After release, the block is in IDLE passing BGM.
- Pulses longer than 1 cycle restart the effect every cycle (caller's responsibility).

## Test plan
Bench overrides: TICK = 100, SHOT_P0 = 20, SHOT_DP = 4, SHOT_LEN = 3, HIT_P0 = 40, HIT_DP = 10, HIT_LEN = 5, BOMB_NP = 8, BOMB_LEN = 4, vol = 7 unless stated.

- Reset: hold rst_n low with bgm_beep toggling → audio_out = 0 and sfx_state = 0. After release, audio_out follows bgm_beep gated by PWM, with 1-cycle delay.
- Shot:
  - Pulse shot at cycle 0 → sfx_state = 1 after that edge.
  - Output period is 20 cycles during ticks 0–99, 24 during 100–199, and 28 during 200–299.
  - IDLE at exactly 300 cycles after entry; BGM resumes.
- Preemption:
  - During SHOT, pulse hit → sfx_state = 2 and period 40.
  - During HIT, pulse shot → ignored; HIT runs to 500 cycles.
  - Pulse hit again mid-HIT → restarts, with a full 500 cycles from the restart edge.
- Simultaneous/edge cases:
  - shot+hit+bomb in the same cycle → BOMB.
  - During BOMB, lfsr advances every 8 cycles and the first step from 16'hACE1 gives 16'h5670.
  - A shot pulse on the final BOMB tick → SHOT entered, not IDLE.
- Volume/mute:
  - vol = 0 → audio_out constantly 0.
  - vol = 3 with src high → exactly 3 high cycles per 8.
  - mute = 1 mid-SHOT → audio_out = 0, but sfx_state still returns to IDLE on schedule.
- Async reset during HIT → audio_out and sfx_state are 0 with no clock edge; after release, IDLE.
